// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and default sizes for the register file.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned ID_WIDTH_DEFAULT   = 4;
    localparam int unsigned NUM_REGS_DEFAULT   = 8;

    typedef logic [ID_WIDTH_DEFAULT-1:0]   reg_id_t;
    typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;

    localparam reg_id_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: id decode to stored value, zero for id 0 and
// nonexistent ids, with write-through bypass of the in-flight write.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned ID_WIDTH   = ID_WIDTH_DEFAULT,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT
) (
    input  logic [ID_WIDTH-1:0]                   read_id_i,
    input  logic [NUM_REGS-1:1][DATA_WIDTH-1:0]   regs_i,
    input  logic                                  bypass_en_i,
    input  logic [ID_WIDTH-1:0]                   write_id_i,
    input  logic [DATA_WIDTH-1:0]                 write_value_i,
    output logic [DATA_WIDTH-1:0]                 read_value_o
);

    always_comb begin
        read_value_o = '0;
        // Only ids 1..NUM_REGS-1 match a slot; id 0 and ids past the end stay zero.
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (read_id_i == ID_WIDTH'(i)) begin
                read_value_o = regs_i[i];
            end
        end
        // bypass_en_i already implies write_id_i is a writable id.
        if (bypass_en_i && (read_id_i == write_id_i)) begin
            read_value_o = write_value_i;
        end
    end

endmodule

// File: rtl/register_block.sv
// 8-bit CPU register file: two combinational read ports, one write port,
// register 0 hardwired to zero and write_id 0 meaning "no write".
module register_block
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned ID_WIDTH   = ID_WIDTH_DEFAULT,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ID_WIDTH-1:0]   read1_id,
    output logic [DATA_WIDTH-1:0] read1_value,
    input  logic [ID_WIDTH-1:0]   read2_id,
    output logic [DATA_WIDTH-1:0] read2_value,
    input  logic [ID_WIDTH-1:0]   write_id,
    input  logic [DATA_WIDTH-1:0] write_value
);

    localparam logic [ID_WIDTH:0] NUM_REGS_W = (ID_WIDTH + 1)'(NUM_REGS);

    logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_d;
    logic                                write_valid;
    logic                                bypass_en;

    assign write_valid = (write_id != ID_WIDTH'(REG_ZERO)) && ({1'b0, write_id} < NUM_REGS_W);
    // Reset clears storage asynchronously, so the bypass must also go quiet.
    assign bypass_en   = write_valid && reset_n;

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (write_valid && (write_id == ID_WIDTH'(i))) begin
                regs_d[i] = write_value;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read1 (
        .read_id_i     (read1_id),
        .regs_i        (regs_q),
        .bypass_en_i   (bypass_en),
        .write_id_i    (write_id),
        .write_value_i (write_value),
        .read_value_o  (read1_value)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read2 (
        .read_id_i     (read2_id),
        .regs_i        (regs_q),
        .bypass_en_i   (bypass_en),
        .write_id_i    (write_id),
        .write_value_i (write_value),
        .read_value_o  (read2_value)
    );

endmodule

// File: tb/tb_register_block.sv
// Directed self-checking bench for register_block.
module tb_register_block;
    import cpu_pkg::*;

    logic    clock;
    logic    reset_n;
    reg_id_t read1_id;
    data_t   read1_value;
    reg_id_t read2_id;
    data_t   read2_value;
    reg_id_t write_id;
    data_t   write_value;

    int unsigned assertions = 0;
    int unsigned failures   = 0;

    register_block #(
        .DATA_WIDTH (8),
        .ID_WIDTH   (4),
        .NUM_REGS   (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .read1_id    (read1_id),
        .read1_value (read1_value),
        .read2_id    (read2_id),
        .read2_value (read2_value),
        .write_id    (write_id),
        .write_value (write_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stimulus changes on the falling edge; outputs sampled 1 time unit later.
    task automatic test_reset();
        reset_n = 1'b0; write_id = 4'd0; write_value = 8'h00; read1_id = 4'd0; read2_id = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1; read1_id = 4'd3; read2_id = 4'd4;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL reset_r1_id3: got %h want %h", read1_value, 8'h00); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL reset_r2_id4: got %h want %h", read2_value, 8'h00); end
    endtask

    task automatic test_zero_nonexistent();
        @(negedge clock);
        read1_id = 4'd0; read2_id = 4'd14;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL zero_id0: got %h want %h", read1_value, 8'h00); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL zero_id14: got %h want %h", read2_value, 8'h00); end
        @(negedge clock);
        write_id = 4'd14; write_value = 8'hFF; read1_id = 4'd14; read2_id = 4'd6;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL nobypass_id14: got %h want %h", read1_value, 8'h00); end
        @(negedge clock);
        write_id = 4'd0;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL write_id14_ignored: got %h want %h", read1_value, 8'h00); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL write_id14_alias6: got %h want %h", read2_value, 8'h00); end
    endtask

    task automatic test_write_bypass();
        @(negedge clock);
        write_id = 4'd2; write_value = 8'h55; read1_id = 4'd2; read2_id = 4'd3;
        #1;
        assertions++;
        if (read1_value !== 8'h55) begin failures++; $display("FAIL bypass_w2: got %h want %h", read1_value, 8'h55); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL bypass_other_id3: got %h want %h", read2_value, 8'h00); end
        @(posedge clock);
        #1;
        assertions++;
        if (read1_value !== 8'h55) begin failures++; $display("FAIL after_edge_w2: got %h want %h", read1_value, 8'h55); end
        @(negedge clock);
        write_id = 4'd0; write_value = 8'h00; read1_id = 4'd3;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL untouched_id3: got %h want %h", read1_value, 8'h00); end
    endtask

    task automatic test_persistence();
        @(negedge clock);
        write_id = 4'd0; write_value = 8'hAA; read1_id = 4'd2; read2_id = 4'd0;
        repeat (3) @(negedge clock);
        #1;
        assertions++;
        if (read1_value !== 8'h55) begin failures++; $display("FAIL persist_id2: got %h want %h", read1_value, 8'h55); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL persist_id0: got %h want %h", read2_value, 8'h00); end
    endtask

    task automatic test_dual_read();
        @(negedge clock);
        write_id = 4'd5; write_value = 8'h3C;
        @(negedge clock);
        write_id = 4'd6; write_value = 8'hC3;
        @(negedge clock);
        write_id = 4'd0; write_value = 8'h00; read1_id = 4'd5; read2_id = 4'd6;
        #1;
        assertions++;
        if (read1_value !== 8'h3C) begin failures++; $display("FAIL dual_r1_id5: got %h want %h", read1_value, 8'h3C); end
        assertions++;
        if (read2_value !== 8'hC3) begin failures++; $display("FAIL dual_r2_id6: got %h want %h", read2_value, 8'hC3); end
        @(negedge clock);
        read2_id = 4'd5;
        #1;
        assertions++;
        if (read1_value !== 8'h3C) begin failures++; $display("FAIL same_r1_id5: got %h want %h", read1_value, 8'h3C); end
        assertions++;
        if (read2_value !== 8'h3C) begin failures++; $display("FAIL same_r2_id5: got %h want %h", read2_value, 8'h3C); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        write_id = 4'd1; write_value = 8'h11;
        @(negedge clock);
        write_id = 4'd1; write_value = 8'h22; read1_id = 4'd1; read2_id = 4'd1;
        #1;
        assertions++;
        if (read1_value !== 8'h22) begin failures++; $display("FAIL b2b_bypass_r1: got %h want %h", read1_value, 8'h22); end
        assertions++;
        if (read2_value !== 8'h22) begin failures++; $display("FAIL b2b_bypass_r2: got %h want %h", read2_value, 8'h22); end
        @(negedge clock);
        write_id = 4'd7; write_value = 8'h7E; read2_id = 4'd7;
        #1;
        assertions++;
        if (read1_value !== 8'h22) begin failures++; $display("FAIL b2b_stored_id1: got %h want %h", read1_value, 8'h22); end
        @(negedge clock);
        write_id = 4'd0; write_value = 8'h00;
        #1;
        assertions++;
        if (read2_value !== 8'h7E) begin failures++; $display("FAIL top_id7: got %h want %h", read2_value, 8'h7E); end
        read1_id = 4'd8;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL first_nonexistent_id8: got %h want %h", read1_value, 8'h00); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        read1_id = 4'd2; read2_id = 4'd5;
        #1;
        assertions++;
        if (read1_value !== 8'h55) begin failures++; $display("FAIL prereset_id2: got %h want %h", read1_value, 8'h55); end
        #1;
        reset_n = 1'b0; write_id = 4'd2; write_value = 8'h99;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL async_reset_id2: got %h want %h", read1_value, 8'h00); end
        assertions++;
        if (read2_value !== 8'h00) begin failures++; $display("FAIL async_reset_id5: got %h want %h", read2_value, 8'h00); end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1; write_id = 4'd0; write_value = 8'h00;
        #1;
        assertions++;
        if (read1_value !== 8'h00) begin failures++; $display("FAIL write_during_reset: got %h want %h", read1_value, 8'h00); end
        @(negedge clock);
        reset_n = 1'b0; write_id = 4'd3; write_value = 8'h33; read1_id = 4'd3;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        write_id = 4'd0; write_value = 8'h00;
        #1;
        assertions++;
        if (read1_value !== 8'h33) begin failures++; $display("FAIL write_after_release: got %h want %h", read1_value, 8'h33); end
    endtask

    initial begin
        test_reset();
        test_zero_nonexistent();
        test_write_bypass();
        test_persistence();
        test_dual_read();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
